// File: rtl/gpioemu_mulcnt_pkg.sv
// Shared constants for the GPIO-emulator multiply/popcount peripheral:
// register offsets, FSM state encodings and STATUS bit positions.
package gpioemu_mulcnt_pkg;

  localparam logic [7:0] OFF_A1   = 8'h00;
  localparam logic [7:0] OFF_A2   = 8'h08;
  localparam logic [7:0] OFF_W    = 8'h10;
  localparam logic [7:0] OFF_L    = 8'h18;
  localparam logic [7:0] OFF_CTRL = 8'h20;
  localparam logic [7:0] OFF_CNT  = 8'h28;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_MULT  = 2'd1;
  localparam state_t ST_COUNT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int unsigned STAT_READY = 1;
  localparam int unsigned STAT_VALID = 0;

  function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [7:0] off);
    return base + {8'h00, off};
  endfunction

endpackage

// File: rtl/gpioemu_shiftadd_mul.sv
// Sequential shift-add multiplier: one multiplier bit (LSB first) per cycle,
// ARG_W cycles after start_i; done_o marks the final accumulation cycle.
module gpioemu_shiftadd_mul #(
  parameter int unsigned ARG_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [ARG_W-1:0]   a_i,
  input  logic [ARG_W-1:0]   b_i,
  output logic               done_o,
  output logic [2*ARG_W-1:0] product_o
);

  localparam int unsigned PW = 2 * ARG_W;
  localparam int unsigned CW = $clog2(ARG_W + 1);

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [ARG_W-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             last_s;

  assign last_s = busy_q && (cnt_q == CW'(ARG_W - 1));

  // Next-state: load operands on start, otherwise one shift-add step while busy.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = {{ARG_W{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d  = mcand_q << 1'b1;
      mplier_d = mplier_q >> 1'b1;
      cnt_d    = cnt_q + CW'(1);
      busy_d   = !last_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign done_o    = last_s;
  assign product_o = acc_q;

endmodule

// File: rtl/gpioemu_mulcnt.sv
// Bus-mapped multiply + popcount peripheral with operation counter on gpio_out.
// Optional macro GPIOEMU_MULCNT_SAT_EN saturates W to all ones on overflow.
module gpioemu_mulcnt
  import gpioemu_mulcnt_pkg::*;
#(
  parameter int unsigned ARG_W     = 24,
  parameter int unsigned RES_W     = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0380,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out
);

  localparam int unsigned PW = 2 * ARG_W;
  localparam int unsigned BW = $clog2(RES_W + 1);

  state_t           state_q, state_d;
  logic [ARG_W-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [RES_W-1:0] w_q, w_d;
  logic [BW-1:0]    l_q, l_d, pop_q, pop_d, idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      insp_q, insp_d;
  logic             sync1_q, sync2_q, prev_q;

  logic             sel_a1_s, sel_a2_s, sel_w_s, sel_l_s, sel_ctrl_s, sel_cnt_s;
  logic             start_s, ready_s, mul_done_s, ovf_s, bit_s, unused_s;
  logic [PW-1:0]    mul_prod_s;
  logic [63:0]      prod64_s;
  logic [RES_W-1:0] prod_low_s, bit_mask_s;
  logic [31:0]      a1_ext_s, a2_ext_s, w_ext_s, l_ext_s, cnt_ext_s, rd_mux_s;

  assign sel_a1_s   = (saddress == reg_addr(BASE_ADDR, OFF_A1));
  assign sel_a2_s   = (saddress == reg_addr(BASE_ADDR, OFF_A2));
  assign sel_w_s    = (saddress == reg_addr(BASE_ADDR, OFF_W));
  assign sel_l_s    = (saddress == reg_addr(BASE_ADDR, OFF_L));
  assign sel_ctrl_s = (saddress == reg_addr(BASE_ADDR, OFF_CTRL));
  assign sel_cnt_s  = (saddress == reg_addr(BASE_ADDR, OFF_CNT));

  assign ready_s  = (state_q == ST_IDLE);
  assign start_s  = swr && sel_ctrl_s && sdata_in[0] && ready_s;
  assign unused_s = ^(sdata_in >> ARG_W);

  gpioemu_shiftadd_mul #(.ARG_W(ARG_W)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_s),
    .a_i       (a1_q),
    .b_i       (a2_q),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s)
  );

  // Product split into stored result, overflow flag and the bit being counted.
  always_comb begin
    prod64_s            = 64'h0;
    prod64_s[PW-1:0]    = mul_prod_s;
    prod_low_s          = prod64_s[RES_W-1:0];
    ovf_s               = |(prod64_s >> RES_W);
    bit_mask_s          = RES_W'(1) << idx_q;
    bit_s               = |(prod_low_s & bit_mask_s);
  end

  // Zero-extension of narrow registers onto the 32-bit bus.
  always_comb begin
    a1_ext_s              = 32'h0;
    a2_ext_s              = 32'h0;
    w_ext_s               = 32'h0;
    l_ext_s               = 32'h0;
    cnt_ext_s             = 32'h0;
    a1_ext_s[ARG_W-1:0]   = a1_q;
    a2_ext_s[ARG_W-1:0]   = a2_q;
    w_ext_s[RES_W-1:0]    = w_q;
    l_ext_s[BW-1:0]       = l_q;
    cnt_ext_s[CNT_W-1:0]  = cnt_q;
  end

  // Read mux and bus-side register updates; reads see pre-write values.
  always_comb begin
    rd_mux_s = 32'h0;
    if (sel_a1_s) begin
      rd_mux_s = a1_ext_s;
    end else if (sel_a2_s) begin
      rd_mux_s = a2_ext_s;
    end else if (sel_w_s) begin
      rd_mux_s = w_ext_s;
    end else if (sel_l_s) begin
      rd_mux_s = l_ext_s;
    end else if (sel_ctrl_s) begin
      rd_mux_s[STAT_READY] = ready_s;
      rd_mux_s[STAT_VALID] = valid_q;
    end else if (sel_cnt_s) begin
      rd_mux_s = cnt_ext_s;
    end else begin
      rd_mux_s = 32'h0;
    end

    if (srd) rdata_d = rd_mux_s;
    else     rdata_d = rdata_q;
    if (swr && sel_a1_s) a1_d = sdata_in[ARG_W-1:0];
    else                 a1_d = a1_q;
    if (swr && sel_a2_s) a2_d = sdata_in[ARG_W-1:0];
    else                 a2_d = a2_q;
    if (sync2_q && !prev_q) insp_d = gpio_in;
    else                    insp_d = insp_q;
  end

  // Operation sequencer: IDLE -> MULT -> COUNT -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    l_d     = l_q;
    pop_d   = pop_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_MULT;
          pop_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (mul_done_s) state_d = ST_COUNT;
        else            state_d = ST_MULT;
      end
      ST_COUNT: begin
        pop_d = pop_q + BW'(bit_s);
        idx_d = idx_q + BW'(1);
        if (idx_q == BW'(RES_W - 1)) state_d = ST_DONE;
        else                         state_d = ST_COUNT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = cnt_q + CNT_W'(1);
        valid_d = !ovf_s;
`ifdef GPIOEMU_MULCNT_SAT_EN
        if (ovf_s) begin
          w_d = '1;
          l_d = BW'(RES_W);
        end else begin
          w_d = prod_low_s;
          l_d = pop_q;
        end
`else
        w_d = prod_low_s;
        l_d = pop_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All architectural state, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a1_q    <= '0;
      a2_q    <= '0;
      w_q     <= '0;
      l_q     <= '0;
      pop_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b1;
      rdata_q <= 32'h0;
      insp_q  <= 32'h0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      w_q     <= w_d;
      l_q     <= l_d;
      pop_q   <= pop_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      insp_q  <= insp_d;
      sync1_q <= gpio_latch;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sdata_out      = rdata_q;
  assign gpio_in_s_insp = insp_q;
  assign gpio_out       = cnt_ext_s;

endmodule

// File: tb/tb_gpioemu_mulcnt.sv
// Randomized + directed bench for gpioemu_mulcnt against an arithmetic reference model.
module tb_gpioemu_mulcnt;

  localparam int unsigned ARG_W  = 24;
  localparam int unsigned RES_W  = 32;
  localparam logic [15:0] BASE   = 16'h0380;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OP_CYC = ARG_W + RES_W + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] saddress = 16'h0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = 32'h0;
  logic [31:0] gpio_in = 32'h0;
  logic        gpio_latch = 1'b0;
  logic [31:0] sdata_out, gpio_in_s_insp, gpio_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpioemu_mulcnt #(.ARG_W(ARG_W), .RES_W(RES_W), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_in_s_insp(gpio_in_s_insp), .gpio_out(gpio_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] popcnt(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return 32'(n);
  endfunction

  // ---------------- reference model ----------------
  bit              model_ok = 1'b0;
  longint unsigned cyc = 0;
  longint unsigned m_fin = 0;
  logic [31:0]     m_a1, m_a2, m_w, m_l, m_rd, m_insp;
  logic [63:0]     m_prod;
  logic [CNT_W-1:0] m_cnt;
  bit              m_valid, m_busy;
  bit              hist[3];
  logic [31:0]     amask = 32'((64'd1 << ARG_W) - 64'd1);
  logic [31:0]     rmask = 32'((64'd1 << RES_W) - 64'd1);

  function automatic logic [31:0] model_read(input logic [15:0] a);
    if (a == BASE + 16'h00)      return m_a1;
    else if (a == BASE + 16'h08) return m_a2;
    else if (a == BASE + 16'h10) return m_w;
    else if (a == BASE + 16'h18) return m_l;
    else if (a == BASE + 16'h20) return {30'h0, !m_busy, m_valid};
    else if (a == BASE + 16'h28) return {16'h0, m_cnt};
    else                         return 32'h0;
  endfunction

  always @(posedge clk) begin
    bit was_busy, ovf;
    if (reset) begin
      model_ok = 1'b1;
      m_a1 = 0; m_a2 = 0; m_w = 0; m_l = 0; m_rd = 0; m_insp = 0;
      m_cnt = 0; m_valid = 1'b1; m_busy = 1'b0; m_prod = 0;
      hist[0] = 1'b0; hist[1] = 1'b0; hist[2] = 1'b0;
    end else begin
      if (srd) m_rd = model_read(saddress);
      was_busy = m_busy;
      if (m_busy && cyc == m_fin) begin
        ovf = ((m_prod >> RES_W) != 64'd0);
`ifdef GPIOEMU_MULCNT_SAT_EN
        m_w = ovf ? rmask : (m_prod[31:0] & rmask);
`else
        m_w = m_prod[31:0] & rmask;
`endif
        m_l = popcnt(m_w);
        m_valid = !ovf;
        m_cnt = m_cnt + 1'b1;
        m_busy = 1'b0;
      end
      if (swr) begin
        if (saddress == BASE + 16'h00) m_a1 = sdata_in & amask;
        else if (saddress == BASE + 16'h08) m_a2 = sdata_in & amask;
        else if (saddress == BASE + 16'h20 && sdata_in[0] && !was_busy) begin
          m_busy = 1'b1;
          m_fin  = cyc + OP_CYC;
          m_prod = {32'h0, m_a1} * {32'h0, m_a2};
        end
      end
      // capture happens when the latch was low three cycles back and high two cycles back
      if (hist[1] && !hist[2]) m_insp = gpio_in;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = gpio_latch;
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      chk("sdata_out", sdata_out, m_rd);
      chk("gpio_out", gpio_out, {16'h0, m_cnt});
      chk("gpio_in_s_insp", gpio_in_s_insp, m_insp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    saddress = BASE + {8'h00, off}; sdata_in = d; swr = 1'b1;
    step();
    swr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    saddress = BASE + {8'h00, off}; srd = 1'b1;
    step();
    srd = 1'b0;
    d = sdata_out;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  off;
    step();
    // 1: reset values
    do_reset(2);
    rd(8'h20, d); chk("rst status", d, 32'h3);
    rd(8'h10, d); chk("rst W", d, 32'h0);
    rd(8'h18, d); chk("rst L", d, 32'h0);
    rd(8'h28, d); chk("rst CNT", d, 32'h0);
    rd(8'h30, d); chk("unmapped 0x30", d, 32'h0);
    rd(8'h04, d); chk("unmapped 0x04", d, 32'h0);
    chk("rst gpio_out", gpio_out, 32'h0);

    // 2: 3*5, ready exactly 58 cycles after start
    wr(8'h00, 32'd3); wr(8'h08, 32'd5);
    wr(8'h20, 32'h1);
    rd(8'h20, d); chk("busy status", d, 32'h1);
    repeat (55) step();
    rd(8'h20, d); chk("status t+57", d, 32'h1);
    rd(8'h20, d); chk("status t+58", d, 32'h3);
    rd(8'h10, d); chk("W 3*5", d, 32'd15);
    rd(8'h18, d); chk("L 3*5", d, 32'd4);
    chk("gpio_out 1", gpio_out, 32'h1);

    // 3: overflow; operand masked to ARG_W bits
    wr(8'h00, 32'hFFFFFFFF); wr(8'h08, 32'h00FFFFFF);
    rd(8'h00, d); chk("A1 masked", d, 32'h00FFFFFF);
    wr(8'h20, 32'h1);
    repeat (60) step();
    rd(8'h20, d); chk("ovf status", d, 32'h2);
`ifdef GPIOEMU_MULCNT_SAT_EN
    rd(8'h10, d); chk("ovf W", d, 32'hFFFFFFFF);
    rd(8'h18, d); chk("ovf L", d, 32'd32);
`else
    rd(8'h10, d); chk("ovf W", d, 32'hFE000001);
    rd(8'h18, d); chk("ovf L", d, 32'd8);
`endif

    // 4: writes while busy only affect the next operation
    do_reset(2);
    wr(8'h00, 32'd2); wr(8'h08, 32'd7);
    wr(8'h20, 32'h1);
    wr(8'h00, 32'd100);
    repeat (8) step();
    wr(8'h20, 32'h1);
    repeat (60) step();
    rd(8'h10, d); chk("W 2*7", d, 32'd14);
    rd(8'h28, d); chk("CNT 1", d, 32'd1);
    wr(8'h20, 32'h1);
    repeat (60) step();
    rd(8'h10, d); chk("W 100*7", d, 32'd700);
    rd(8'h28, d); chk("CNT 2", d, 32'd2);

    // 5: reset mid-operation aborts
    wr(8'h00, 32'd9); wr(8'h08, 32'd9);
    wr(8'h20, 32'h1);
    repeat (19) step();
    do_reset(1);
    repeat (80) step();
    rd(8'h20, d); chk("abort status", d, 32'h3);
    rd(8'h10, d); chk("abort W", d, 32'h0);
    rd(8'h28, d); chk("abort CNT", d, 32'h0);
    rd(8'h00, d); chk("abort A1", d, 32'h0);

    // 6: latch capture after three cycles, stable until next edge
    gpio_in = 32'hA5A5A5A5; gpio_latch = 1'b1;
    step(); step();
    chk("insp before", gpio_in_s_insp, 32'h0);
    step();
    chk("insp captured", gpio_in_s_insp, 32'hA5A5A5A5);
    gpio_in = 32'h12345678;
    repeat (5) step();
    chk("insp held", gpio_in_s_insp, 32'hA5A5A5A5);
    gpio_latch = 1'b0;
    repeat (3) step();
    gpio_latch = 1'b1;
    repeat (3) step();
    chk("insp second", gpio_in_s_insp, 32'h12345678);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 8000; i++) begin
      reset = ($urandom_range(0, 1499) == 0);
      srd   = ($urandom_range(0, 2) == 0);
      swr   = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 7))
        0: off = 8'h00;
        1: off = 8'h08;
        2: off = 8'h10;
        3: off = 8'h18;
        4: off = 8'h20;
        5: off = 8'h28;
        6: off = 8'h30;
        default: off = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 15) == 0) saddress = 16'($urandom);
      else                            saddress = BASE + {8'h00, off};
      case ($urandom_range(0, 3))
        0: sdata_in = 32'($urandom_range(0, 15));
        1: sdata_in = 32'hFFFFFFFF;
        2: sdata_in = 32'($urandom_range(0, 1023));
        default: sdata_in = $urandom;
      endcase
      gpio_in = $urandom;
      if ($urandom_range(0, 3) == 0) gpio_latch = !gpio_latch;
      step();
    end
    reset = 1'b0; srd = 1'b0; swr = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
